mil1553_tx: RTL and testbench

MIL1553_TX -- requirements
Module: mil1553_tx

---
 rtl/mil1553_pkg.sv | 24 ++
 rtl/m1553_bit_timer.sv | 28 ++
 rtl/mil1553_tx.sv | 123 ++++++++++++
 tb/tb_mil1553_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mil1553_pkg.sv
// Shared constants, word_type encodings and FSM state encoding for the
// MIL-STD-1553 word transmitter.
package mil1553_pkg;

    localparam int CLK_PER_HALF   = 4;
    localparam int SYNC_HALF_CLKS = 12;
    localparam int DATA_BITS      = 16;

    localparam logic [1:0] WT_SYNC_LH = 2'b01;
    localparam logic [1:0] WT_SYNC_HL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PARITY,
        ST_GAP
    } state_t;

    function automatic logic wt_valid(input logic [1:0] wt);
        return (wt == WT_SYNC_LH) || (wt == WT_SYNC_HL);
    endfunction

endpackage

// File: rtl/m1553_bit_timer.sv
// Bit-cell timer: a 3-bit phase counter giving the half-bit indicator and
// the bit-end tick for Manchester data and parity cells.
module m1553_bit_timer
    import mil1553_pkg::*;
(
    input  logic clk_8M,
    input  logic clrn,
    input  logic clr,
    input  logic en,
    output logic second_half,
    output logic bit_end
);

    logic [2:0] phase;

    always_ff @(posedge clk_8M or negedge clrn) begin
        if (!clrn)
            phase <= '0;
        else if (clr)
            phase <= '0;
        else if (en)
            phase <= phase + 3'd1;
    end

    assign second_half = (phase >= 3'(CLK_PER_HALF));
    assign bit_end     = en && (phase == 3'(2 * CLK_PER_HALF - 1));

endmodule

// File: rtl/mil1553_tx.sv
// MIL-STD-1553 word transmitter: sync, 16 Manchester data bits, odd parity,
// then a fixed bus-idle gap. Line outputs are registered one clock behind the FSM.
module mil1553_tx
    import mil1553_pkg::*;
#(
    parameter int GAP_CLKS = 32
) (
    input  logic        clk_8M,
    input  logic        clrn,
    input  logic [15:0] data_in,
    input  logic [1:0]  word_type,
    input  logic        start,
    output logic        ready,
    output logic        tx_out,
    output logic        tx_en,
    output logic        done,
    output logic        err
);

    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    state_t               state, state_nx;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_idx;
    logic [4:0]           sync_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 sync_first, par_bit, rdy_q;
    logic                 accept, timer_clr, timer_en, second_half, bit_end;
    logic                 tx_out_d, tx_en_d, done_d;

    // rdy_q is registered so ready stays low while clrn is asserted
    assign ready     = rdy_q;
    assign accept    = rdy_q && start && wt_valid(word_type);
    assign timer_en  = (state == ST_DATA) || (state == ST_PARITY);
    assign timer_clr = (state_nx != state);

    m1553_bit_timer u_timer (
        .clk_8M      (clk_8M),
        .clrn        (clrn),
        .clr         (timer_clr),
        .en          (timer_en),
        .second_half (second_half),
        .bit_end     (bit_end)
    );

    always_comb begin
        state_nx = state;
        tx_en_d  = 1'b0;
        tx_out_d = 1'b0;
        done_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nx = ST_SYNC;
            end
            ST_SYNC: begin
                tx_en_d  = 1'b1;
                tx_out_d = (sync_cnt < 5'(SYNC_HALF_CLKS)) ? sync_first : !sync_first;
                if (sync_cnt == 5'(2 * SYNC_HALF_CLKS - 1))
                    state_nx = ST_DATA;
            end
            ST_DATA: begin
                tx_en_d  = 1'b1;
                tx_out_d = shreg[DATA_BITS-1] ^ second_half;
                if (bit_end && (bit_idx == 4'(DATA_BITS - 1)))
                    state_nx = ST_PARITY;
            end
            ST_PARITY: begin
                tx_en_d  = 1'b1;
                tx_out_d = par_bit ^ second_half;
                done_d   = bit_end;
                if (bit_end)
                    state_nx = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CLKS - 1))
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_8M or negedge clrn) begin
        if (!clrn) begin
            state    <= ST_IDLE;
            rdy_q    <= 1'b0;
            err      <= 1'b0;
            tx_out   <= 1'b0;
            tx_en    <= 1'b0;
            done     <= 1'b0;
            sync_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nx;
            rdy_q    <= (state_nx == ST_IDLE);
            err      <= rdy_q && start && !wt_valid(word_type);
            tx_out   <= tx_out_d;
            tx_en    <= tx_en_d;
            done     <= done_d;
            sync_cnt <= (state == ST_SYNC && state_nx == ST_SYNC) ? sync_cnt + 5'd1 : '0;
            gap_cnt  <= (state == ST_GAP && state_nx == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

    // Payload, sync polarity and parity are frozen at acceptance
    always_ff @(posedge clk_8M or negedge clrn) begin
        if (!clrn) begin
            shreg      <= '0;
            bit_idx    <= '0;
            sync_first <= 1'b0;
            par_bit    <= 1'b0;
        end else if (accept) begin
            shreg      <= data_in;
            bit_idx    <= '0;
            sync_first <= (word_type == WT_SYNC_HL);
            par_bit    <= ~^data_in;
        end else if (state == ST_DATA && bit_end) begin
            shreg      <= shreg << 1;
            bit_idx    <= bit_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_mil1553_tx.sv
// Directed + randomized bench for mil1553_tx; expected line waveforms come from
// a per-clock reference list built from the word format rules.
module tb_mil1553_tx;

    localparam int GAP = 32;

    logic        clk_8M = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [1:0]  word_type = '0;
    logic        ready, tx_out, tx_en, done, err;

    int   checks = 0;
    int   errors = 0;
    logic exp_w [160];

    mil1553_tx #(.GAP_CLKS(GAP)) dut (
        .clk_8M    (clk_8M),
        .clrn      (clrn),
        .data_in   (data_in),
        .word_type (word_type),
        .start     (start),
        .ready     (ready),
        .tx_out    (tx_out),
        .tx_en     (tx_en),
        .done      (done),
        .err       (err)
    );

    always #5 clk_8M = ~clk_8M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for each of the 160 clocks of a word
    task automatic build(input logic [15:0] d, input logic [1:0] wt);
        int   p, ones;
        logic s, par;
        p    = 0;
        ones = 0;
        s    = (wt == 2'b10);
        for (int i = 0; i < 12; i++) begin exp_w[p] = s;  p = p + 1; end
        for (int i = 0; i < 12; i++) begin exp_w[p] = !s; p = p + 1; end
        for (int b = 15; b >= 0; b--) begin
            if (d[b]) ones = ones + 1;
            for (int i = 0; i < 4; i++) begin exp_w[p] = d[b];  p = p + 1; end
            for (int i = 0; i < 4; i++) begin exp_w[p] = !d[b]; p = p + 1; end
        end
        par = ((ones % 2) == 0);
        for (int i = 0; i < 4; i++) begin exp_w[p] = par;  p = p + 1; end
        for (int i = 0; i < 4; i++) begin exp_w[p] = !par; p = p + 1; end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(negedge clk_8M);
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
    endtask

    // Checks n clocks of the word starting at the first tx_en=1 sample
    task automatic watch(input int n, input bit poke);
        int w;
        w = 0;
        while (tx_en !== 1'b1 && w < 1000) begin
            @(negedge clk_8M);
            w++;
        end
        chk("word_start", 32'(tx_en), 32'd1);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("tx_out[%0d]", k), 32'(tx_out), 32'(exp_w[k]));
            chk($sformatf("tx_en[%0d]", k), 32'(tx_en), 32'd1);
            chk($sformatf("done[%0d]", k), 32'(done), 32'(k == 159));
            chk($sformatf("err_busy[%0d]", k), 32'(err), 32'd0);
            if (poke && k == 40) begin start = 1'b1; word_type = 2'b11; end
            if (poke && k == 41) start = 1'b0;
            @(negedge clk_8M);
        end
        if (n == 160) begin
            chk("tx_en_fall", 32'(tx_en), 32'd0);
            chk("done_fall", 32'(done), 32'd0);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] wt, input int n, input bit poke);
        wait_ready();
        data_in   = d;
        word_type = wt;
        start     = 1'b1;
        build(d, wt);
        @(posedge clk_8M);
        @(negedge clk_8M);
        start = 1'b0;
        chk("latency_en_low", 32'(tx_en), 32'd0);
        chk("ready_drop", 32'(ready), 32'd0);
        // Inputs change right after acceptance; the word must not follow them
        data_in   = 16'($urandom);
        word_type = 2'($urandom);
        @(negedge clk_8M);
        chk("latency_en_high", 32'(tx_en), 32'd1);
        chk("first_sync", 32'(tx_out), 32'(exp_w[0]));
        watch(n, poke);
    endtask

    initial begin
        logic [1:0] wt;
        int         lo;

        repeat (3) @(negedge clk_8M);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_out", 32'(tx_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        clrn = 1'b1;
        #1 chk("ready_before_edge", 32'(ready), 32'd0);
        @(posedge clk_8M);
        #1 chk("ready_after_reset", 32'(ready), 32'd1);
        @(negedge clk_8M);

        send(16'h3582, 2'b01, 160, 1'b0);
        send(16'hFFFF, 2'b10, 160, 1'b0);

        // Invalid word_type in IDLE
        wait_ready();
        word_type = 2'b11;
        data_in   = 16'h1234;
        start     = 1'b1;
        @(posedge clk_8M);
        @(negedge clk_8M);
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_tx_en", 32'(tx_en), 32'd0);
        chk("err_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_8M);
            chk("err_single", 32'(err), 32'd0);
            chk("err_idle_en", 32'(tx_en), 32'd0);
            chk("err_idle_ready", 32'(ready), 32'd1);
        end

        repeat (4) begin
            wt = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            send(16'($urandom), wt, 160, 1'b0);
        end

        // start held high: back-to-back words separated by the gap plus one idle clock
        wait_ready();
        data_in   = 16'h0000;
        word_type = 2'b01;
        start     = 1'b1;
        build(16'h0000, 2'b01);
        for (int w = 0; w < 3; w++) begin
            watch(160, 1'b0);
            if (w < 2) begin
                lo = 0;
                while (tx_en !== 1'b1 && lo < 1000) begin
                    lo++;
                    @(negedge clk_8M);
                end
                chk("gap_len", 32'(lo), 32'(GAP + 1));
            end
        end
        start = 1'b0;

        // Reset at clock 80 of a word, with an invalid start poked while busy
        send(16'($urandom), 2'b10, 80, 1'b1);
        #1 clrn = 1'b0;
        #1;
        chk("abort_tx_en", 32'(tx_en), 32'd0);
        chk("abort_tx_out", 32'(tx_out), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk_8M);
        clrn = 1'b1;
        @(posedge clk_8M);
        #1 chk("ready_after_abort", 32'(ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_8M);
            chk("no_resume", 32'(tx_en), 32'd0);
        end
        send(16'($urandom), 2'b01, 160, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
